// File: rtl/mips_data_mem_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Signal names follow the pipeline's existing control-signal names.
interface mips_data_mem_if;
    logic        req;
    logic        MemWrite;
    logic        Byte;
    logic        Half;
    logic        UnsignedExt_Mem;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        ready;
    logic        clr_busy;
    logic        rvalid;
    logic [31:0] data_out;
    logic        misalign;

    modport master (
        output req, MemWrite, Byte, Half, UnsignedExt_Mem, addr, data_in,
        input  ready, clr_busy, rvalid, data_out, misalign
    );

    modport slave (
        input  req, MemWrite, Byte, Half, UnsignedExt_Mem, addr, data_in,
        output ready, clr_busy, rvalid, data_out, misalign
    );
endinterface

// File: rtl/mips_data_mem.sv
// Banked MIPS data memory: four byte lanes, sized/extended loads, misalign flagging,
// and a one-word-per-cycle clear sweep after CLR. Loads return two edges after accept.

module mips_data_mem_lane #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem_q [0:(1<<AW)-1];
    logic [7:0] rdata_q;

    // Synchronous read port so each lane maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

module mips_data_mem #(
    parameter int ADDR_SIZE = 10
) (
    input  logic            clk,
    input  logic            CLR,
    mips_data_mem_if.slave  bus
);
    localparam int NUM_LANES = 4;
    localparam int WAW       = ADDR_SIZE - 2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    typedef struct packed {
        logic       load;
        logic       mis;
        logic       is_byte;
        logic       is_half;
        logic       uns;
        logic [1:0] off;
    } pend_t;

    logic [0:0]     state_q, state_d;
    logic [WAW-1:0] cnt_q, cnt_d;
    logic           pvld_q, pvld_d;
    pend_t          pend_q, pend_d;
    logic           rvalid_q, rvalid_d;
    logic           misalign_q, misalign_d;
    logic [31:0]    dout_q, dout_d;

    logic           accept, mis, st_en, ld_en;
    logic [1:0]     off;
    logic [WAW-1:0] word_idx;
    logic [NUM_LANES-1:0]      be, lane_we;
    logic [WAW-1:0]            lane_waddr;
    logic [NUM_LANES-1:0][7:0] lane_wdata, st_data, rd_lane;
    logic [7:0]                bsel;
    logic [15:0]               hsel;
    logic [31:0]               ld_val;
    logic                      unused_addr_hi;

    assign unused_addr_hi = ^bus.addr[31:ADDR_SIZE];

    assign off      = bus.addr[1:0];
    assign word_idx = bus.addr[ADDR_SIZE-1:2];
    assign accept   = bus.req & (state_q == ST_IDLE) & ~CLR;
    assign mis      = bus.Byte ? 1'b0 : (bus.Half ? off[0] : |off);
    assign st_en    = accept &  bus.MemWrite & ~mis;
    assign ld_en    = accept & ~bus.MemWrite & ~mis;

    // Store data is replicated across lanes; the enables pick which lanes land.
    always_comb begin
        be      = 4'b1111;
        st_data = bus.data_in;
        if (bus.Byte) begin
            be      = 4'b0001 << off;
            st_data = {4{bus.data_in[7:0]}};
        end else if (bus.Half) begin
            be      = off[1] ? 4'b1100 : 4'b0011;
            st_data = {2{bus.data_in[15:0]}};
        end
    end

    always_comb begin
        if (state_q == ST_CLEAR) begin
            lane_we    = '1;
            lane_waddr = cnt_q;
            lane_wdata = '0;
        end else begin
            lane_we    = st_en ? be : '0;
            lane_waddr = word_idx;
            lane_wdata = st_data;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mips_data_mem_lane #(.AW(WAW)) u_lane (
            .clk     (clk),
            .we_i    (lane_we[l]),
            .waddr_i (lane_waddr),
            .wdata_i (lane_wdata[l]),
            .re_i    (ld_en),
            .raddr_i (word_idx),
            .rdata_o (rd_lane[l])
        );
    end

    always_comb begin
        bsel = rd_lane[pend_q.off];
        hsel = pend_q.off[1] ? rd_lane[3:2] : rd_lane[1:0];
        if (pend_q.is_byte)      ld_val = {{24{~pend_q.uns & bsel[7]}}, bsel};
        else if (pend_q.is_half) ld_val = {{16{~pend_q.uns & hsel[15]}}, hsel};
        else                     ld_val = rd_lane;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = ST_IDLE;
        end

        pvld_d         = accept;
        pend_d.load    = ~bus.MemWrite;
        pend_d.mis     = mis;
        pend_d.is_byte = bus.Byte;
        pend_d.is_half = ~bus.Byte & bus.Half;
        pend_d.uns     = bus.UnsignedExt_Mem;
        pend_d.off     = off;

        rvalid_d   = 1'b0;
        misalign_d = 1'b0;
        dout_d     = dout_q;
        if (pvld_q) begin
            misalign_d = pend_q.mis;
            if (pend_q.load) begin
                rvalid_d = 1'b1;
                dout_d   = pend_q.mis ? 32'h0 : ld_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            pvld_q     <= 1'b0;
            pend_q     <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            dout_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pvld_q     <= pvld_d;
            pend_q     <= pend_d;
            rvalid_q   <= rvalid_d;
            misalign_q <= misalign_d;
            dout_q     <= dout_d;
        end
    end

    assign bus.ready    = (state_q == ST_IDLE);
    assign bus.clr_busy = (state_q == ST_CLEAR);
    assign bus.rvalid   = rvalid_q;
    assign bus.misalign = misalign_q;
    assign bus.data_out = dout_q;
endmodule

// File: tb/tb_mips_data_mem.sv
// Directed bench: a 16-word instance (sweep timing) and a 256-word instance (wrap),
// both fed the same request stream.
module tb_mips_data_mem;
    logic clk = 1'b0;
    logic CLR;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mips_data_mem_if bif();
    mips_data_mem_if sif();

    assign sif.req             = bif.req;
    assign sif.MemWrite        = bif.MemWrite;
    assign sif.Byte            = bif.Byte;
    assign sif.Half            = bif.Half;
    assign sif.UnsignedExt_Mem = bif.UnsignedExt_Mem;
    assign sif.addr            = bif.addr;
    assign sif.data_in         = bif.data_in;

    mips_data_mem #(.ADDR_SIZE(10)) u_big   (.clk(clk), .CLR(CLR), .bus(bif.slave));
    mips_data_mem #(.ADDR_SIZE(6))  u_small (.clk(clk), .CLR(CLR), .bus(sif.slave));

    logic        got_rv, got_mis, s_rv;
    logic [31:0] got_d, s_d;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b, input logic h);
        bif.req = 1'b1; bif.MemWrite = 1'b1; bif.Byte = b; bif.Half = h;
        bif.UnsignedExt_Mem = 1'b0; bif.addr = a; bif.data_in = d;
        @(negedge clk);
        bif.req = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic b, input logic h, input logic u);
        bif.req = 1'b1; bif.MemWrite = 1'b0; bif.Byte = b; bif.Half = h;
        bif.UnsignedExt_Mem = u; bif.addr = a;
        @(negedge clk);
        bif.req = 1'b0;
        @(negedge clk);
        got_rv = bif.rvalid; got_d = bif.data_out; got_mis = bif.misalign;
        s_rv = sif.rvalid; s_d = sif.data_out;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(bif.ready && sif.ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(bif.ready && sif.ready)) begin
            errors++;
            $display("FAIL wait_ready: ready big=%b small=%b, required 1/1", bif.ready, sif.ready);
        end
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        bif.req = 1'b0; bif.MemWrite = 1'b0; bif.Byte = 1'b0; bif.Half = 1'b0;
        bif.UnsignedExt_Mem = 1'b0; bif.addr = '0; bif.data_in = '0;
        @(negedge clk);
        checks += 5;
        if (bif.ready !== 1'b0)    begin errors++; $display("FAIL rst_ready: got %b want 0", bif.ready); end
        if (bif.clr_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", bif.clr_busy); end
        if (bif.rvalid !== 1'b0)   begin errors++; $display("FAIL rst_rvalid: got %b want 0", bif.rvalid); end
        if (bif.misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", bif.misalign); end
        if (bif.data_out !== 32'h0) begin errors++; $display("FAIL rst_dout: got %h want 0", bif.data_out); end
        CLR = 1'b0;
        wait_ready();
    endtask

    task automatic test_sweep();
        int n;
        for (int i = 0; i < 16; i++) store(32'(i * 4), 32'hA500_0000 | 32'(i + 1), 1'b0, 1'b0);
        load(32'h3C, 1'b0, 1'b0, 1'b0);
        checks++;
        if (s_d !== 32'hA500_0010) begin errors++; $display("FAIL preload: got %h want a5000010", s_d); end

        CLR = 1'b1;
        @(negedge clk);
        CLR = 1'b0;
        n = 0;
        while (sif.clr_busy && !sif.ready && n < 40) begin n++; @(negedge clk); end
        checks += 2;
        if (n !== 16) begin errors++; $display("FAIL sweep_len: got %0d cycles want 16", n); end
        if (sif.ready !== 1'b1 || sif.clr_busy !== 1'b0) begin
            errors++; $display("FAIL sweep_end: ready=%b busy=%b want 1/0", sif.ready, sif.clr_busy);
        end
        for (int i = 0; i < 16; i++) begin
            load(32'(i * 4), 1'b0, 1'b0, 1'b0);
            checks++;
            if (s_rv !== 1'b1 || s_d !== 32'h0) begin
                errors++; $display("FAIL cleared_w%0d: rvalid=%b data=%h want 1/0", i, s_rv, s_d);
            end
        end

        CLR = 1'b1;
        @(negedge clk);
        CLR = 1'b0;
        repeat (7) @(negedge clk);
        CLR = 1'b1;
        @(negedge clk);
        CLR = 1'b0;
        n = 0;
        while (sif.clr_busy && !sif.ready && n < 40) begin n++; @(negedge clk); end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL restart_len: got %0d cycles want 16", n); end
        wait_ready();
    endtask

    task automatic test_byte();
        store(32'h10, 32'h0000_0000, 1'b0, 1'b0);
        store(32'h12, 32'h0000_0085, 1'b1, 1'b0);
        load(32'h10, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_rv !== 1'b1 || got_d !== 32'h0085_0000) begin
            errors++; $display("FAIL byte_word: rv=%b got %h want 00850000", got_rv, got_d);
        end
        load(32'h12, 1'b1, 1'b0, 1'b0);
        checks++;
        if (got_d !== 32'hFFFF_FF85) begin errors++; $display("FAIL byte_signed: got %h want ffffff85", got_d); end
        load(32'h12, 1'b1, 1'b0, 1'b1);
        checks++;
        if (got_d !== 32'h0000_0085) begin errors++; $display("FAIL byte_unsigned: got %h want 00000085", got_d); end
    endtask

    task automatic test_half_word();
        store(32'h20, 32'h1234_8001, 1'b0, 1'b0);
        load(32'h20, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_d !== 32'h1234_8001) begin errors++; $display("FAIL word_fwd: got %h want 12348001", got_d); end
        load(32'h20, 1'b0, 1'b1, 1'b0);
        checks++;
        if (got_d !== 32'hFFFF_8001) begin errors++; $display("FAIL half_signed: got %h want ffff8001", got_d); end
        load(32'h22, 1'b0, 1'b1, 1'b1);
        checks++;
        if (got_d !== 32'h0000_1234) begin errors++; $display("FAIL half_unsigned: got %h want 00001234", got_d); end
        store(32'h26, 32'h7777_BEEF, 1'b0, 1'b1);
        load(32'h24, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_d !== 32'hBEEF_0000) begin errors++; $display("FAIL half_store_hi: got %h want beef0000", got_d); end
        load(32'h23, 1'b1, 1'b0, 1'b0);
        checks++;
        if (got_d !== 32'h0000_0012 || got_mis !== 1'b0) begin
            errors++; $display("FAIL byte_odd: got %h mis=%b want 00000012/0", got_d, got_mis);
        end
    endtask

    task automatic test_misalign();
        store(32'h30, 32'h1122_3344, 1'b0, 1'b0);
        store(32'h31, 32'h0000_BEEF, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (bif.misalign !== 1'b1 || bif.rvalid !== 1'b0) begin
            errors++; $display("FAIL mis_half_st: mis=%b rv=%b want 1/0", bif.misalign, bif.rvalid);
        end
        store(32'h22, 32'hDEAD_BEEF, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bif.misalign !== 1'b1) begin errors++; $display("FAIL mis_word_st: mis=%b want 1", bif.misalign); end
        @(negedge clk);
        checks++;
        if (bif.misalign !== 1'b0) begin errors++; $display("FAIL mis_drop: mis=%b want 0", bif.misalign); end
        load(32'h30, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_d !== 32'h1122_3344) begin errors++; $display("FAIL mis_unchanged30: got %h want 11223344", got_d); end
        load(32'h20, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_d !== 32'h1234_8001) begin errors++; $display("FAIL mis_unchanged20: got %h want 12348001", got_d); end
        load(32'h21, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_rv !== 1'b1 || got_mis !== 1'b1 || got_d !== 32'h0) begin
            errors++; $display("FAIL mis_load: rv=%b mis=%b data=%h want 1/1/0", got_rv, got_mis, got_d);
        end
    endtask

    task automatic test_back_to_back();
        store(32'h404, 32'hCAFE_F00D, 1'b0, 1'b0);
        store(32'h000, 32'h0102_0304, 1'b0, 1'b0);
        store(32'h008, 32'h0A0B_0C0D, 1'b0, 1'b0);
        load(32'h004, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_d !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap: got %h want cafef00d", got_d); end

        bif.req = 1'b1; bif.MemWrite = 1'b0; bif.Byte = 1'b0; bif.Half = 1'b0; bif.addr = 32'h0;
        @(negedge clk);
        bif.addr = 32'h4;
        @(negedge clk);
        checks++;
        if (bif.rvalid !== 1'b1 || bif.data_out !== 32'h0102_0304) begin
            errors++; $display("FAIL b2b_0: rv=%b got %h want 1/01020304", bif.rvalid, bif.data_out);
        end
        bif.addr = 32'h8;
        @(negedge clk);
        checks++;
        if (bif.rvalid !== 1'b1 || bif.data_out !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL b2b_1: rv=%b got %h want 1/cafef00d", bif.rvalid, bif.data_out);
        end
        bif.req = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.rvalid !== 1'b1 || bif.data_out !== 32'h0A0B_0C0D) begin
            errors++; $display("FAIL b2b_2: rv=%b got %h want 1/0a0b0c0d", bif.rvalid, bif.data_out);
        end
        @(negedge clk);
        checks++;
        if (bif.rvalid !== 1'b0 || bif.data_out !== 32'h0A0B_0C0D) begin
            errors++; $display("FAIL hold: rv=%b got %h want 0/0a0b0c0d", bif.rvalid, bif.data_out);
        end
    endtask

    task automatic test_clr_inflight();
        bif.req = 1'b1; bif.MemWrite = 1'b0; bif.Byte = 1'b0; bif.Half = 1'b0; bif.addr = 32'h4;
        @(negedge clk);
        bif.req = 1'b0;
        CLR = 1'b1;
        @(negedge clk);
        CLR = 1'b0;
        checks += 2;
        if (bif.rvalid !== 1'b0 || bif.data_out !== 32'h0) begin
            errors++; $display("FAIL clr_inflight: rv=%b data=%h want 0/0", bif.rvalid, bif.data_out);
        end
        if (bif.ready !== 1'b0 || bif.clr_busy !== 1'b1) begin
            errors++; $display("FAIL clr_state: ready=%b busy=%b want 0/1", bif.ready, bif.clr_busy);
        end
        @(negedge clk);
        checks++;
        if (bif.rvalid !== 1'b0) begin errors++; $display("FAIL clr_norv: rv=%b want 0", bif.rvalid); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_byte();
        test_half_word();
        test_misalign();
        test_back_to_back();
        test_clr_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
